// File: rtl/epcs_flash_responder.sv
// epcs_flash_responder
// Device end of an EPCS serial-flash link. It decodes READ (03), READ STATUS (05)
// and READ SILICON ID (AB) and streams bytes from a preloadable internal memory
// back on epcs_data0 (SPI mode 0, MSB first).
// Optional feature macro: EPCS_RESP_FAST_READ_EN adds decoding of FAST READ (0B).
// Ports:
//   clk_clk, reset_reset         system clock, synchronous active-high reset
//   epcs_dclk/sce/sdo            serial link inputs from the controller (async)
//   epcs_data0, epcs_data0_oe    serial data back to the controller and its enable
//   mem_wr_en/addr/data          parallel preload write port
//   busy                         transaction in progress
module epcs_flash_responder #(
   parameter int unsigned ADDR_W     = 8,
   parameter logic [7:0]  SILICON_ID = 8'h16
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              epcs_dclk,
   input  logic              epcs_sce,
   input  logic              epcs_sdo,
   output logic              epcs_data0,
   output logic              epcs_data0_oe,
   input  logic              mem_wr_en,
   input  logic [ADDR_W-1:0] mem_wr_addr,
   input  logic [7:0]        mem_wr_data,
   output logic              busy
);

   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam logic [7:0]  OP_READ = 8'h03;
   localparam logic [7:0]  OP_RDSR = 8'h05;
   localparam logic [7:0]  OP_RDID = 8'hAB;
`ifdef EPCS_RESP_FAST_READ_EN
   localparam logic [7:0]  OP_FAST = 8'h0B;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_OPCODE   = 3'd1,
      S_ADDR     = 3'd2,
      S_DUMMY    = 3'd3,
      S_DATA     = 3'd4,
      S_STATUS   = 3'd5,
      S_IDSTREAM = 3'd6,
      S_IGNORE   = 3'd7
   } state_t;

   logic [7:0]        r_mem [DEPTH];
   logic [1:0]        r_dclk_sync;
   logic [1:0]        r_sce_sync;
   logic [1:0]        r_sdo_sync;
   logic              r_dclk_prev;
   logic              r_seen_sce_high;
   state_t            r_state;
   logic [2:0]        r_bit_cnt;
   logic [1:0]        r_byte_cnt;
   logic [1:0]        r_dummy_last;
   logic              r_id_after_dummy;
   logic              r_fast;
   logic [6:0]        r_shift_in;
   logic [7:0]        r_shift_out;
   logic [ADDR_W-1:0] r_addr;
   logic              r_data0;
   logic              r_data0_oe;
   logic              r_busy;

   logic              w_sce;
   logic              w_sdo;
   logic              w_dclk_rise;
   logic              w_dclk_fall;
   logic              w_byte_done;
   logic [7:0]        w_byte_in;
   logic [7:0]        w_out_byte;

   assign w_sce       = r_sce_sync[1];
   assign w_sdo       = r_sdo_sync[1];
   assign w_dclk_rise = r_dclk_sync[1] & ~r_dclk_prev;
   assign w_dclk_fall = ~r_dclk_sync[1] & r_dclk_prev;
   assign w_byte_done = w_dclk_rise && (r_bit_cnt == 3'd7);
   assign w_byte_in   = {r_shift_in, w_sdo};

   assign epcs_data0    = r_data0;
   assign epcs_data0_oe = r_data0_oe;
   assign busy          = r_busy;

   // Byte to be launched at the start of the next output byte; a same-cycle
   // preload write is not visible here yet, so the old value is returned.
   always_comb begin
      w_out_byte = 8'h00;
      case (r_state)
         S_DATA:     w_out_byte = r_mem[r_addr];
         S_IDSTREAM: w_out_byte = SILICON_ID;
         default:    w_out_byte = 8'h00;
      endcase
   end

   // Preload port, accepted every cycle.
   always_ff @(posedge clk_clk) begin
      if (mem_wr_en) r_mem[mem_wr_addr] <= mem_wr_data;
   end

   // Synchronizers, edge detect and the protocol state machine.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_dclk_sync      <= 2'b00;
         r_sce_sync       <= 2'b00;
         r_sdo_sync       <= 2'b00;
         r_dclk_prev      <= 1'b0;
         r_seen_sce_high  <= 1'b0;
         r_state          <= S_IDLE;
         r_bit_cnt        <= 3'd0;
         r_byte_cnt       <= 2'd0;
         r_dummy_last     <= 2'd0;
         r_id_after_dummy <= 1'b0;
         r_fast           <= 1'b0;
         r_shift_in       <= 7'd0;
         r_shift_out      <= 8'd0;
         r_addr           <= '0;
         r_data0          <= 1'b0;
         r_data0_oe       <= 1'b0;
         r_busy           <= 1'b0;
      end else begin
         r_dclk_sync <= {r_dclk_sync[0], epcs_dclk};
         r_sce_sync  <= {r_sce_sync[0], epcs_sce};
         r_sdo_sync  <= {r_sdo_sync[0], epcs_sdo};
         r_dclk_prev <= r_dclk_sync[1];

         if (w_sce) begin
            // Deselect aborts everything, including a partial byte.
            r_seen_sce_high <= 1'b1;
            r_state         <= S_IDLE;
            r_bit_cnt       <= 3'd0;
            r_byte_cnt      <= 2'd0;
            r_data0         <= 1'b0;
            r_data0_oe      <= 1'b0;
            r_busy          <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  // A frame already running when reset was released is skipped.
                  if (r_seen_sce_high) begin
                     r_state   <= S_OPCODE;
                     r_busy    <= 1'b1;
                     r_bit_cnt <= 3'd0;
                  end
               end

               S_OPCODE: begin
                  if (w_dclk_rise) begin
                     r_shift_in <= w_byte_in[6:0];
                     r_bit_cnt  <= r_bit_cnt + 3'd1;
                  end
                  if (w_byte_done) begin
                     r_byte_cnt       <= 2'd0;
                     r_fast           <= 1'b0;
                     r_id_after_dummy <= 1'b0;
                     case (w_byte_in)
                        OP_READ: r_state <= S_ADDR;
                        OP_RDSR: r_state <= S_STATUS;
                        OP_RDID: begin
                           r_state          <= S_DUMMY;
                           r_dummy_last     <= 2'd2;
                           r_id_after_dummy <= 1'b1;
                        end
`ifdef EPCS_RESP_FAST_READ_EN
                        OP_FAST: begin
                           r_state <= S_ADDR;
                           r_fast  <= 1'b1;
                        end
`endif
                        default: r_state <= S_IGNORE;
                     endcase
                  end
               end

               S_ADDR: begin
                  // Shifting all 24 bits through leaves only the low ADDR_W bits.
                  if (w_dclk_rise) begin
                     r_addr    <= {r_addr[ADDR_W-2:0], w_sdo};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
                  if (w_byte_done) begin
                     if (r_byte_cnt == 2'd2) begin
                        r_byte_cnt <= 2'd0;
                        if (r_fast) begin
                           r_state      <= S_DUMMY;
                           r_dummy_last <= 2'd0;
                        end else begin
                           r_state <= S_DATA;
                        end
                     end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                     end
                  end
               end

               S_DUMMY: begin
                  if (w_dclk_rise) r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (w_byte_done) begin
                     if (r_byte_cnt == r_dummy_last) begin
                        r_byte_cnt <= 2'd0;
                        r_state    <= r_id_after_dummy ? S_IDSTREAM : S_DATA;
                     end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                     end
                  end
               end

               S_DATA, S_STATUS, S_IDSTREAM: begin
                  // Bit counter now tracks falling edges; bit 0 loads a new byte.
                  if (w_dclk_fall) begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd0) begin
                        r_data0     <= w_out_byte[7];
                        r_shift_out <= {w_out_byte[6:0], 1'b0};
                        r_data0_oe  <= 1'b1;
                        if (r_state == S_DATA) r_addr <= r_addr + ADDR_W'(1);
                     end else begin
                        r_data0     <= r_shift_out[7];
                        r_shift_out <= {r_shift_out[6:0], 1'b0};
                     end
                  end
               end

               default: begin
                  r_data0    <= 1'b0;
                  r_data0_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/epcs_flash_responder.md
# epcs_flash_responder

Synthesizable serial-flash responder that plays the device end of the EPCS link driven by the wallet's EPCS flash controller. It decodes the controller's serial commands (READ, READ STATUS, READ SILICON ID) and streams bytes from an internal byte memory back on `data0`. The memory is preloaded through a parallel write port. The block is used as an on-chip stand-in for the configuration flash in loopback builds and in system-level benches.

## Interface
Parameters:
- `ADDR_W`, 8: byte-address width of the internal memory; depth is 2^ADDR_W bytes.
- `SILICON_ID`, 8'h16: byte returned by READ SILICON ID.

Ports:
- `clk_clk`  in  1  system clock; all logic is on its rising edge.
- `reset_reset`  in  1  synchronous, active-high reset.
- `epcs_dclk`  in  1  serial clock from the controller; asynchronous to `clk_clk`; frequency ≤ clk/8.
- `epcs_sce`  in  1  chip select, active low.
- `epcs_sdo`  in  1  controller→responder serial data; MSB first.
- `epcs_data0`  out  1  responder→controller serial data; MSB first.
- `epcs_data0_oe`  out  1  output enable for `epcs_data0`; high only while returning data.
- `mem_wr_en`  in  1  preload write strobe.
- `mem_wr_addr`  in  ADDR_W  preload byte address.
- `mem_wr_data`  in  8  preload byte.
- `busy`  out  1  high while a transaction is in progress (`epcs_sce` synchronized low and not in IDLE).

## Operation
- `epcs_dclk`, `epcs_sce` and `epcs_sdo` each pass through a 2-flop synchronizer. Edges are detected on the synchronized `dclk`.
- On each rising edge, `sdo` is shifted in. On each falling edge, the next `data0` bit is shifted out. This is SPI mode 0: the controller samples on rising edges.
- States:
  - IDLE: entered on synchronized `sce` high. Goes to OPCODE on `sce` low.
  - OPCODE: after 8 bits, the opcode selects the next state.
    - 8'h03 → ADDR.
    - 8'h05 → STATUS.
    - 8'hAB → DUMMY (3 bytes).
    - Any other opcode → IGNORE.
  - ADDR: 24 bits are shifted in. The low ADDR_W bits are kept as the start address; upper bits are discarded. Then → DATA.
  - DUMMY: counts the required dummy bytes, then → DATA (READ) or IDSTREAM.
  - DATA: returns `mem[addr]`, then increments addr. The address wraps from 2^ADDR_W-1 to 0. This continues until `sce` goes high.
  - STATUS: returns 8'h00 repeatedly (WIP=0, WEL=0).
  - IDSTREAM: returns SILICON_ID repeatedly.
  - IGNORE: `data0_oe`=0 and `data0`=0 until `sce` goes high.
- The output byte is loaded into the shift register on the falling edge that starts each byte. Its MSB appears on `data0` at that edge.
- Synchronized `sce` going high in any state forces IDLE in the next cycle. A partial byte is discarded.
- Bit counter is 3 bits; byte counters saturate. There is no overflow behaviour beyond address wrap.
- Preload writes are accepted every cycle in any state. If a write and a byte load hit the same address in the same cycle, the loaded byte is the old memory value.

## Timing
- Reset values: `epcs_data0`=0, `epcs_data0_oe`=0, `busy`=0, state=IDLE, all counters 0.
- After reset, the block stays in IDLE until synchronized `sce` has been seen high at least once. A transaction in flight during reset is therefore ignored until the next `sce` falling edge.
- Input-pin-to-edge-detect latency: 3 `clk_clk` cycles. Falling `dclk` at pin to new `data0` at pin: ≤ 4 cycles, which is within a half period at dclk ≤ clk/8.
- READ: the first data bit is driven on the falling `dclk` edge after the 32nd rising edge. `data0_oe` rises on that same cycle.
- STATUS: the first bit is driven on the falling edge after the 8th rising edge.
- `data0_oe` falls within 1 cycle of synchronized `sce` going high.

## Configuration
- `EPCS_RESP_FAST_READ_EN` defined: opcode 8'h0B (FAST READ) is decoded. It takes 24 address bits, then 1 dummy byte, then data exactly as READ. The first data bit is driven after the 40th rising edge.
- Not defined: 8'h0B goes to IGNORE.

## Test plan
- Preload mem[0x10..0x13]=DE AD BE EF; send 03 00 00 10, then clock 32 bits → `data0` bytes DE AD BE EF; `data0_oe`=1 only during data.
- Preload mem[0xFF]=0x5A and mem[0x00]=0xA5; READ at 0x0000FF for 2 bytes → 5A then A5 (wrap). Address 0x1234FF gives the same result (upper bits discarded).
- Send 05, then 16 bits → 00 00. Send AB + 3 dummy bytes, then 16 bits → 16 16.
- Send opcode 0x9F → `data0`=0 and `data0_oe`=0 for the whole frame. The next frame, READ at 0x10, returns DE correctly.
- Raise `sce` after 4 data bits; start a new READ at 0x11 → AD. Assert `reset_reset` mid-READ → outputs 0 at once; no response until `sce` toggles high then low.
- With `EPCS_RESP_FAST_READ_EN` defined: 0B 00 00 10 + 1 dummy byte → DE AD. Without it, the same frame gives silence.
